// File: rtl/exc_pkg.sv
// Shared exception-code definitions for the per-stage exception registers.
package exc_pkg;

    localparam int unsigned CODE_W_DEF = 5;

    localparam logic [4:0] NO_EXC      = 5'h1F;
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

endpackage

// File: rtl/exc_prio_merge.sv
// Fixed-priority merge: upstream exception first, then lowest-index local source.
module exc_prio_merge
    import exc_pkg::*;
#(
    parameter int unsigned NSRC   = 4,
    parameter int unsigned CODE_W = CODE_W_DEF
) (
    input  logic                     valid_in,
    input  logic [CODE_W-1:0]        exc_in,
    input  logic [NSRC-1:0]          src_valid,
    input  logic [NSRC*CODE_W-1:0]   src_code,
    output logic [CODE_W-1:0]        merged_code
);

    localparam logic [CODE_W-1:0] L_NO_EXC = CODE_W'(NO_EXC);

    always_comb begin
        logic v_hit;
        v_hit       = 1'b0;
        merged_code = L_NO_EXC;
        if (valid_in) begin
            if (exc_in != L_NO_EXC) begin
                merged_code = exc_in;
            end else begin
                for (int unsigned i = 0; i < NSRC; i++) begin
                    if (!v_hit && src_valid[i]) begin
                        merged_code = src_code[i*CODE_W +: CODE_W];
                        v_hit       = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/exc_stage_reg.sv
// Pipeline-stage exception register with CP0 req/ack handshake and a
// saturating count of accepted exceptions.
module exc_stage_reg
    import exc_pkg::*;
#(
    parameter int unsigned NSRC   = 4,
    parameter int unsigned CODE_W = CODE_W_DEF,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     valid_in,
    input  logic [CODE_W-1:0]        exc_in,
    input  logic [NSRC-1:0]          src_valid,
    input  logic [NSRC*CODE_W-1:0]   src_code,
    input  logic [PC_W-1:0]          pc_in,
    input  logic                     bd_in,
    input  logic                     exc_ack,
    input  logic                     cnt_clr,
    output logic                     valid_out,
    output logic [CODE_W-1:0]        exc_out,
    output logic [PC_W-1:0]          pc_out,
    output logic                     bd_out,
    output logic                     exc_req,
    output logic                     hold_out,
    output logic [CNT_W-1:0]         exc_count
);

    localparam logic [CODE_W-1:0] L_NO_EXC = CODE_W'(NO_EXC);

    logic                r_valid;
    logic [CODE_W-1:0]   r_exc;
    logic [PC_W-1:0]     r_pc;
    logic                r_bd;
    logic [CNT_W-1:0]    r_count;

    logic [CODE_W-1:0]   w_merged;
    logic                w_exc_req;
    logic                w_accept;

    exc_prio_merge #(
        .NSRC   (NSRC),
        .CODE_W (CODE_W)
    ) u_merge (
        .valid_in    (valid_in),
        .exc_in      (exc_in),
        .src_valid   (src_valid),
        .src_code    (src_code),
        .merged_code (w_merged)
    );

    // Request decoded from registers only, so reset drops it asynchronously.
    assign w_exc_req = r_valid && (r_exc != L_NO_EXC);
    assign w_accept  = w_exc_req && exc_ack && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_exc   <= L_NO_EXC;
            r_pc    <= '0;
            r_bd    <= 1'b0;
        end else if (flush || (w_exc_req && exc_ack)) begin
            r_valid <= 1'b0;
            r_exc   <= L_NO_EXC;
            r_pc    <= '0;
            r_bd    <= 1'b0;
        end else if (!w_exc_req && en) begin
            r_valid <= valid_in;
            r_exc   <= w_merged;
            r_pc    <= pc_in;
            r_bd    <= bd_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (cnt_clr) begin
            r_count <= w_accept ? CNT_W'(1) : '0;
        end else if (w_accept && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign valid_out = r_valid;
    assign exc_out   = r_exc;
    assign pc_out    = r_pc;
    assign bd_out    = r_bd;
    assign exc_req   = w_exc_req;
    assign hold_out  = w_exc_req && !exc_ack;
    assign exc_count = r_count;

endmodule
